// File: rtl/tilt_pkg.sv
// rtl/tilt_pkg.sv - shared FSM state type and width helpers for tilt_bargraph
package tilt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILT,
    ST_LVL,
    ST_COMMIT
  } tilt_state_e;

  function automatic int level_width(input int nled);
    return $clog2(nled + 1);
  endfunction

  function automatic int chan_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/tilt_bargraph_if.sv
// rtl/tilt_bargraph_if.sv - sample input and LED/status output bundle of tilt_bargraph
interface tilt_bargraph_if #(
  parameter int CH   = 2,
  parameter int DW   = 10,
  parameter int NLED = 2
) ();

  logic                 sample_valid;
  logic [CH*DW-1:0]     axis_data;
  logic                 clr_ovr;
  logic [CH*NLED-1:0]   led_plus;
  logic [CH*NLED-1:0]   led_minus;
  logic                 led_flat;
  logic                 busy;
  logic                 update;
  logic                 overrun;
  logic                 stale;

  modport master (
    output sample_valid, axis_data, clr_ovr,
    input  led_plus, led_minus, led_flat, busy, update, overrun, stale
  );

  modport slave (
    input  sample_valid, axis_data, clr_ovr,
    output led_plus, led_minus, led_flat, busy, update, overrun, stale
  );

endinterface

// File: rtl/tilt_ema_step.sv
// rtl/tilt_ema_step.sv - one channel's EMA update and hysteretic bar level step
module tilt_ema_step
  import tilt_pkg::*;
#(
  parameter int DW    = 10,
  parameter int EMA_K = 2,
  parameter int NLED  = 2,
  parameter int STEP  = 32,
  parameter int HYST  = 4,
  localparam int AW   = DW + EMA_K,
  localparam int LW   = level_width(NLED)
) (
  input  logic signed [AW-1:0] acc,
  input  logic signed [DW-1:0] x,
  input  logic [LW-1:0]        level,
  input  logic                 side,
  input  logic                 seed,
  output logic signed [AW-1:0] acc_next,
  output logic [LW-1:0]        level_next,
  output logic                 side_next
);

  logic signed [AW:0]   sum;
  logic signed [DW-1:0] y;
  logic [DW-1:0]        mag;
  int                   m;
  int                   lv;

  assign y = acc[AW-1:EMA_K];

  always_comb begin
    sum      = (AW+1)'(acc) + (AW+1)'(x) - (AW+1)'(acc >>> EMA_K);
    acc_next = seed ? (AW'(x) <<< EMA_K) : sum[AW-1:0];
  end

  // Magnitude of the most negative sample is 2^(DW-1), which still fits unsigned.
  always_comb begin
    mag        = y[DW-1] ? DW'(-y) : DW'(y);
    m          = int'(mag);
    lv         = int'(level);
    level_next = level;
    if (lv < NLED && m >= (lv + 1) * STEP + HYST)
      level_next = level + 1'b1;
    else if (lv > 0 && m + HYST < lv * STEP)
      level_next = level - 1'b1;
    // The side latches the sign while the bar is empty, so a bar leaving rest takes the current sign.
    side_next = side;
    if (level == '0 || level_next == '0)
      side_next = ~y[DW-1];
  end

endmodule

// File: rtl/tilt_bargraph.sv
// rtl/tilt_bargraph.sv - multi-channel EMA-filtered tilt bar display with stale and overrun flags
module tilt_bargraph
  import tilt_pkg::*;
#(
  parameter int CH          = 2,
  parameter int DW          = 10,
  parameter int NLED        = 2,
  parameter int STEP        = 32,
  parameter int HYST        = 4,
  parameter int EMA_K       = 2,
  parameter int TIMEOUT_CYC = 36000000
) (
  input logic        clk,
  input logic        rst_n,
  tilt_bargraph_if.slave bus
);

  localparam int AW = DW + EMA_K;
  localparam int LW = level_width(NLED);
  localparam int CW = chan_width(CH);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  tilt_state_e          state, state_next;
  logic [CW-1:0]        chan;
  logic [CH*DW-1:0]     cap;
  logic signed [AW-1:0] acc_q [CH];
  logic [LW-1:0]        lvl_q [CH];
  logic                 side_q [CH];
  logic                 seed;
  logic [TW-1:0]        tmo;

  logic [CH*NLED-1:0]   led_plus_q, led_minus_q;
  logic                 led_flat_q, update_q, overrun_q, stale_q;

  logic signed [DW-1:0] x_sel;
  logic signed [AW-1:0] acc_step;
  logic [LW-1:0]        lvl_step;
  logic                 side_step;
  logic [CH*NLED-1:0]   plus_disp, minus_disp;
  logic                 all_flat;
  logic                 accept;
  logic                 last_chan;

  assign accept    = bus.sample_valid && (state == ST_IDLE);
  assign last_chan = (chan == CW'(CH - 1));
  assign x_sel     = cap[chan*DW +: DW];

  tilt_ema_step #(
    .DW    (DW),
    .EMA_K (EMA_K),
    .NLED  (NLED),
    .STEP  (STEP),
    .HYST  (HYST)
  ) u_step (
    .acc        (acc_q[chan]),
    .x          (x_sel),
    .level      (lvl_q[chan]),
    .side       (side_q[chan]),
    .seed       (seed),
    .acc_next   (acc_step),
    .level_next (lvl_step),
    .side_next  (side_step)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (bus.sample_valid) state_next = ST_FILT;
      ST_FILT:   state_next = ST_LVL;
      ST_LVL:    state_next = last_chan ? ST_COMMIT : ST_FILT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    plus_disp  = '1;
    minus_disp = '1;
    all_flat   = 1'b1;
    for (int c = 0; c < CH; c++) begin
      if (lvl_q[c] != '0) all_flat = 1'b0;
      for (int i = 0; i < NLED; i++) begin
        if (i < int'(lvl_q[c])) begin
          if (side_q[c]) plus_disp[c*NLED+i]  = 1'b0;
          else           minus_disp[c*NLED+i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      chan        <= '0;
      cap         <= '0;
      seed        <= 1'b1;
      tmo         <= '0;
      led_plus_q  <= '1;
      led_minus_q <= '1;
      led_flat_q  <= 1'b0;
      update_q    <= 1'b0;
      overrun_q   <= 1'b0;
      stale_q     <= 1'b1;
      for (int c = 0; c < CH; c++) begin
        acc_q[c]  <= '0;
        lvl_q[c]  <= '0;
        side_q[c] <= 1'b1;
      end
    end else begin
      state    <= state_next;
      update_q <= 1'b0;

      if (bus.sample_valid && state != ST_IDLE) overrun_q <= 1'b1;
      else if (bus.clr_ovr)                     overrun_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.sample_valid) begin
            cap  <= bus.axis_data;
            chan <= '0;
          end
        end
        ST_FILT: acc_q[chan] <= acc_step;
        ST_LVL: begin
          lvl_q[chan]  <= lvl_step;
          side_q[chan] <= side_step;
          if (!last_chan) chan <= chan + 1'b1;
        end
        ST_COMMIT: begin
          led_plus_q  <= plus_disp;
          led_minus_q <= minus_disp;
          led_flat_q  <= all_flat;
          update_q    <= 1'b1;
          stale_q     <= 1'b0;
          seed        <= 1'b0;
        end
        default: ;
      endcase

      // An accepted strobe restarts the count, so it wins over a coincident expiry.
      if (accept) begin
        tmo <= '0;
      end else if (TIMEOUT_CYC > 0 && tmo != TW'(TIMEOUT_CYC)) begin
        tmo <= tmo + 1'b1;
        if (tmo == TW'(TIMEOUT_CYC - 1)) begin
          stale_q     <= 1'b1;
          seed        <= 1'b1;
          led_plus_q  <= '1;
          led_minus_q <= '1;
          led_flat_q  <= 1'b0;
          for (int c = 0; c < CH; c++) lvl_q[c] <= '0;
        end
      end
    end
  end

  assign bus.led_plus  = led_plus_q;
  assign bus.led_minus = led_minus_q;
  assign bus.led_flat  = led_flat_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.update    = update_q;
  assign bus.overrun   = overrun_q;
  assign bus.stale     = stale_q;

endmodule
